// File: rtl/fpu_pkg.sv
// Shared floating-point package for the binary32 square-root datapath:
// encoding constants, operand classes and the issue-controller state type.
package fpu_pkg;

    localparam logic [31:0] FP_QNAN  = 32'h7FC0_0000;
    localparam logic [31:0] FP_PINF  = 32'h7F80_0000;
    localparam int          EXP_W    = 8;
    localparam int          MAN_W    = 23;
    localparam int          BIAS     = 127;

    // Operand class as seen by the issue controller
    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        SUBNORM = 3'd1,
        NORMAL  = 3'd2,
        INF     = 3'd3,
        NAN     = 3'd4
    } fp_class_t;

    // Issue/retire FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } fsqrt_state_t;

    // Same-sign zero of a binary32 value
    function automatic logic [31:0] signed_zero(input logic sign);
        return {sign, 31'd0};
    endfunction

endpackage

// File: rtl/fp_classify.sv
// Combinational binary32 classifier: splits an operand into its class and sign.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [31:0] a,
    output fp_class_t   cls,
    output logic        sign
);

    logic [EXP_W-1:0] exp_s;
    logic [MAN_W-1:0] man_s;

    assign sign  = a[31];
    assign exp_s = a[30:MAN_W];
    assign man_s = a[MAN_W-1:0];

    // Decode exponent/mantissa fields into an operand class
    always_comb begin
        cls = NORMAL;
        if (exp_s == {EXP_W{1'b0}}) begin
            if (man_s == {MAN_W{1'b0}}) begin
                cls = ZERO;
            end else begin
                cls = SUBNORM;
            end
        end else if (exp_s == {EXP_W{1'b1}}) begin
            if (man_s == {MAN_W{1'b0}}) begin
                cls = INF;
            end else begin
                cls = NAN;
            end
        end else begin
            cls = NORMAL;
        end
    end

endmodule

// File: rtl/fsqrt_issue_ctrl.sv
// Issue/retire controller in front of the binary32 square-root core.
// Special operands are answered directly; normal operands are held on
// core_a for LATENCY cycles and the core result is then captured.
// Optional feature macro: FSQRT_FTZ_EN (flush subnormal inputs to zero).
// Only XLEN=32 (binary32) is supported.
module fsqrt_issue_ctrl
    import fpu_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_a,
    output logic [XLEN-1:0] core_a,
    input  logic [XLEN-1:0] core_result,
    input  logic            core_overflow,
    input  logic            core_underflow,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            out_invalid,
    output logic            out_overflow,
    output logic            out_underflow
);

    localparam int CNT_W = $clog2(LATENCY + 1);

`ifdef FSQRT_FTZ_EN
    localparam logic FTZ_EN = 1'b1;
`else
    localparam logic FTZ_EN = 1'b0;
`endif

    fsqrt_state_t     state_r;
    logic [CNT_W-1:0] cnt_r;

    fp_class_t        cls_s;
    logic             sign_s;
    logic             byp_s;
    logic [31:0]      byp_result_s;
    logic             byp_invalid_s;
    logic             byp_underflow_s;

    fp_classify u_classify (
        .a    (in_a),
        .cls  (cls_s),
        .sign (sign_s)
    );

    // Bypass decision and result for special operands, in priority order
    always_comb begin
        byp_s           = 1'b0;
        byp_result_s    = 32'd0;
        byp_invalid_s   = 1'b0;
        byp_underflow_s = 1'b0;
        if (cls_s == NAN) begin
            byp_s         = 1'b1;
            byp_result_s  = FP_QNAN;
            byp_invalid_s = 1'b1;
        end else if (FTZ_EN && (cls_s == SUBNORM)) begin
            // flushed subnormal behaves as a same-sign zero, signalling underflow
            byp_s           = 1'b1;
            byp_result_s    = signed_zero(sign_s);
            byp_underflow_s = 1'b1;
        end else if (cls_s == ZERO) begin
            byp_s        = 1'b1;
            byp_result_s = signed_zero(sign_s);
        end else if (sign_s) begin
            // any negative nonzero operand, including -inf and -subnormal
            byp_s         = 1'b1;
            byp_result_s  = FP_QNAN;
            byp_invalid_s = 1'b1;
        end else if (cls_s == INF) begin
            byp_s        = 1'b1;
            byp_result_s = FP_PINF;
        end else begin
            byp_s = 1'b0;
        end
    end

    // Issue/retire FSM with registered handshake, operand and result outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            in_ready      <= 1'b1;
            out_valid     <= 1'b0;
            out_result    <= {XLEN{1'b0}};
            out_invalid   <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            core_a        <= {XLEN{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        in_ready <= 1'b0;
                        if (byp_s) begin
                            out_result    <= byp_result_s;
                            out_invalid   <= byp_invalid_s;
                            out_overflow  <= 1'b0;
                            out_underflow <= byp_underflow_s;
                            out_valid     <= 1'b1;
                            state_r       <= HOLD;
                        end else begin
                            core_a  <= in_a;
                            cnt_r   <= CNT_W'(LATENCY);
                            state_r <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        out_result    <= core_result;
                        out_invalid   <= 1'b0;
                        out_overflow  <= core_overflow;
                        out_underflow <= core_underflow;
                        out_valid     <= 1'b1;
                        state_r       <= HOLD;
                    end
                end
                HOLD: begin
                    // in_ready stays low here, so a same-cycle operand waits for IDLE
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fsqrt_issue_ctrl.sv
// Scoreboard bench for fsqrt_issue_ctrl with a scripted sqrt core stub.
module tb_fsqrt_issue_ctrl;

    localparam int LAT = 3;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] core_a;
    logic [31:0] core_result;
    logic        core_overflow;
    logic        core_underflow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_invalid;
    logic        out_overflow;
    logic        out_underflow;

    fsqrt_issue_ctrl #(.XLEN(32), .LATENCY(LAT)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_a           (in_a),
        .core_a         (core_a),
        .core_result    (core_result),
        .core_overflow  (core_overflow),
        .core_underflow (core_underflow),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_result     (out_result),
        .out_invalid    (out_invalid),
        .out_overflow   (out_overflow),
        .out_underflow  (out_underflow)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Core stub: scripted result valid from LATENCY cycles after core_a changes
    logic [31:0] stub_res = 32'd0;
    logic        stub_of  = 1'b0;
    logic        stub_uf  = 1'b0;
    logic [31:0] last_a   = 32'd0;
    int          age      = 0;

    always @(posedge clk) begin
        if (core_a !== last_a) begin
            last_a <= core_a;
            age    <= 1;
        end else if (age != 0 && age < 100) begin
            age <= age + 1;
        end
    end

    assign core_result    = (age >= LAT - 1) ? stub_res : 32'hDEAD_BEEF;
    assign core_overflow  = (age >= LAT - 1) ? stub_of  : 1'b1;
    assign core_underflow = (age >= LAT - 1) ? stub_uf  : 1'b1;

    typedef struct {
        logic [31:0] res;
        logic        inv;
        logic        of;
        logic        uf;
        int          cyc;
        string       name;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Monitor: pops expectations when a result appears and checks hold stability
    initial begin : monitor
        exp_t        e;
        logic        active;
        logic        prev_hs;
        logic [31:0] h_res;
        logic [2:0]  h_flags;
        active  = 1'b0;
        prev_hs = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                active  = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) begin
                    chk("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
                    chk("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
                end
                prev_hs = 1'b0;
                if (out_valid) begin
                    if (!active) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_output: got %h with no pending operand", out_result);
                        end else begin
                            e = exp_q.pop_front();
                            chk({e.name, "_result"}, out_result, e.res);
                            chk({e.name, "_flags"}, {29'd0, out_invalid, out_overflow, out_underflow},
                                {29'd0, e.inv, e.of, e.uf});
                            chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
                        end
                        active  = 1'b1;
                        h_res   = out_result;
                        h_flags = {out_invalid, out_overflow, out_underflow};
                    end else begin
                        chk("hold_result_stable", out_result, h_res);
                        chk("hold_flags_stable", {29'd0, out_invalid, out_overflow, out_underflow},
                            {29'd0, h_flags});
                    end
                    chk("hold_in_ready_low", {31'd0, in_ready}, 32'd0);
                    if (out_ready) begin
                        active  = 1'b0;
                        prev_hs = 1'b1;
                    end
                end
            end
        end
    end

    // Present an operand, wait for acceptance, record the expected response
    task automatic issue(input logic [31:0] a, input logic [31:0] res, input logic inv,
                         input logic of, input logic uf, input int lat, input string nm);
        int   n;
        exp_t e;
        in_a     = a;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL %s_accept_timeout: in_ready %b expected 1", nm, in_ready);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            e.res  = res;
            e.inv  = inv;
            e.of   = of;
            e.uf   = uf;
            e.cyc  = cyc + lat;
            e.name = nm;
            exp_q.push_back(e);
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    // Wait until every pending result has been delivered
    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d pending, required 0", exp_q.size());
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = 32'd0;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_out_result", out_result, 32'd0);
        chk("reset_flags", {29'd0, out_invalid, out_overflow, out_underflow}, 32'd0);
        chk("reset_core_a", core_a, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // normal operands through the core
        stub_res = 32'h4000_0000; stub_of = 1'b0; stub_uf = 1'b0;
        issue(32'h4080_0000, 32'h4000_0000, 1'b0, 1'b0, 1'b0, LAT, "sqrt4");
        chk("sqrt4_core_a", core_a, 32'h4080_0000);
        wait_idle();
        stub_res = 32'h40A0_0000; stub_of = 1'b1; stub_uf = 1'b0;
        issue(32'h41C8_0000, 32'h40A0_0000, 1'b0, 1'b1, 1'b0, LAT, "sqrt25_of");
        wait_idle();

        // negative operand bypass leaves core_a alone
        issue(32'hC080_0000, QNAN, 1'b1, 1'b0, 1'b0, 0, "neg4");
        chk("neg4_core_a", core_a, 32'h41C8_0000);
        wait_idle();

        // special operand bypasses
        issue(32'h7F80_0000, 32'h7F80_0000, 1'b0, 1'b0, 1'b0, 0, "pinf");
        wait_idle();
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 0, "nzero");
        wait_idle();
        issue(32'h7FA0_0000, QNAN, 1'b1, 1'b0, 1'b0, 0, "snan");
        wait_idle();
        issue(32'hFF80_0000, QNAN, 1'b1, 1'b0, 1'b0, 0, "ninf");
        wait_idle();
        issue(32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0, "pzero");
        wait_idle();

        // backpressure, then a new operand offered together with out_ready
        out_ready = 1'b0;
        issue(32'hC100_0000, QNAN, 1'b1, 1'b0, 1'b0, 0, "bp_neg");
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        stub_res = 32'h3F80_0000; stub_of = 1'b0; stub_uf = 1'b0;
        issue(32'h3F80_0000, 32'h3F80_0000, 1'b0, 1'b0, 1'b0, LAT, "after_bp");
        wait_idle();

        // reset on the second WAIT cycle aborts the operation
        stub_res = 32'h4040_0000; stub_of = 1'b0; stub_uf = 1'b0;
        in_a     = 32'h4110_0000;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_wait_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_wait_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (8) @(negedge clk);
        chk("rst_wait_no_late_output", {31'd0, out_valid}, 32'd0);

        // subnormal operands
`ifdef FSQRT_FTZ_EN
        issue(32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1'b1, 0, "psubn_ftz");
        wait_idle();
        issue(32'h8000_0001, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 0, "nsubn_ftz");
        wait_idle();
`else
        stub_res = 32'h1A35_04F3; stub_of = 1'b0; stub_uf = 1'b1;
        issue(32'h0000_0001, 32'h1A35_04F3, 1'b0, 1'b0, 1'b1, LAT, "psubn_core");
        chk("psubn_core_a", core_a, 32'h0000_0001);
        wait_idle();
        issue(32'h8000_0001, QNAN, 1'b1, 1'b0, 1'b0, 0, "nsubn");
        wait_idle();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
